trig_pair_fetch: RTL and testbench
==================================

// Module: trig_pair_fetch
// PURPOSE
// - Upstream sequencer for the combinational sine/cosine LUT. Accepts one angle request
//   (degrees, arbitrary range) and reduces it to [0,359]. Drives the LUT twice (sine,
//   then cosine) and returns the registered sin/cos pair to the rotation datapath.
// - Handshake is valid/ready on both sides. One request is in flight at a time.
// PARAMETERS
// - ANGLE_W     16  width of in_angle (signed when TRIG_SIGNED_EN is defined, else unsigned)
// - DATA_W      32  width of LUT value and of sin_out/cos_out (opaque, passed through)
// - NORM_STEPS  7   modulo-reduction steps; legal iff 360*2^NORM_STEPS > max |in_angle|
// PORTS
// - clk         in   1        clock, rising edge
// - rst         in   1        synchronous reset, active-high
// - in_valid    in   1        request valid
// - in_ready    out  1        block can accept; high only in IDLE
// - in_angle    in   ANGLE_W  requested angle, degrees
// - lut_op_sel  out  1        to LUT op_selector: 0 = sine, 1 = cosine
// - lut_angle   out  32       to LUT angle, zero-extended normalized angle, 0..359
// - lut_value   in   DATA_W   from LUT value, combinational w.r.t. lut_angle/lut_op_sel
// - out_valid   out  1        result pair valid
// - out_ready   in   1        consumer accepts pair
// - sin_out     out  DATA_W   registered sine
// - cos_out     out  DATA_W   registered cosine
// - angle_out   out  9        normalized angle used, 0..359
// BEHAVIOUR
// - Reset: state=IDLE; out_valid=0; sin_out=cos_out=0; angle_out=0; lut_op_sel=0;
//   lut_angle=0; step counter=0. Reset in any state aborts the request; no partial output.
// - FSM states: IDLE -> NORM -> SIN -> COS -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid&in_ready, latch rem=|in_angle| and neg=sign; set
//     k=NORM_STEPS-1; go to NORM.
//   - NORM: one step per cycle: if rem >= (360<<k) then rem -= (360<<k). Decrement k.
//     Leave after NORM_STEPS cycles (after the step at k=0). Then apply fold: if neg and
//     rem!=0, then rem = 360-rem. Go to SIN.
//   - SIN: lut_op_sel=0, lut_angle=rem. Capture lut_value into sin_out at the cycle end.
//     Go to COS.
//   - COS: lut_op_sel=1, lut_angle=rem. Capture into cos_out and set angle_out=rem.
//     Go to DONE.
//   - DONE: out_valid=1. sin_out/cos_out/angle_out are stable. On out_ready go to IDLE and
//     deassert out_valid at that edge.
// - lut_op_sel/lut_angle are registered from the FSM. Outside SIN/COS they hold their
//   last value; consumers must ignore them.
// - Latency: accepting edge E0 -> out_valid high after edge E0+NORM_STEPS+2 (9 with
//   defaults). Throughput: one pair per NORM_STEPS+4 cycles when out_ready is held high.
// - in_valid asserted outside IDLE is ignored (in_ready=0); the requester holds it.
// - Full-width arithmetic: rem is ANGLE_W+1 bits unsigned. The magnitude of the most
//   negative input is representable. Result is always in 0..359, so 360 maps to 0.
// - out_ready asserted while out_valid=0 has no effect.
// CONFIGURATION
// - TRIG_SIGNED_EN defined: in_angle is two's-complement. Negative angles are folded as
//   above (-90 -> 270).
// - TRIG_SIGNED_EN undefined: in_angle is unsigned, neg is forced 0, and the fold logic
//   is absent.
// TESTING
// - in_angle=30 -> SIN drives (0,30) and COS drives (1,30). sin_out/cos_out equal the LUT
//   model values; angle_out=30; out_valid at edge E0+9.
// - in_angle=725 -> lut_angle=5 in SIN and COS; angle_out=5.
// - in_angle=360 -> angle_out=0. in_angle=0 -> angle_out=0.
// - TRIG_SIGNED_EN, in_angle=-90 -> angle_out=270. in_angle=-32768 -> angle_out=352.
// - out_ready low 5 cycles in DONE -> out_valid and outputs held; in_ready=0 throughout.
//   The next request is accepted only after the out handshake.
// - rst pulsed in NORM (3rd cycle) -> next cycle IDLE, in_ready=1, out_valid=0, outputs 0.
//   A fresh request of 45 completes normally.

Source files
------------

// File: rtl/trig_pair_fetch.sv
// Angle-reduction sequencer for the sin/cos LUT. It reduces an angle in degrees to 0..359,
// reads sine and then cosine from the LUT, and presents the pair with a valid/ready handshake.
// Optional feature: define TRIG_SIGNED_EN for two's-complement in_angle with negative-angle fold.
module trig_pair_fetch #(
    parameter int unsigned ANGLE_W    = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NORM_STEPS = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ANGLE_W-1:0] in_angle,
    output logic               lut_op_sel,
    output logic [31:0]        lut_angle,
    input  logic [DATA_W-1:0]  lut_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  sin_out,
    output logic [DATA_W-1:0]  cos_out,
    output logic [8:0]         angle_out
);

    localparam int unsigned REM_W = ANGLE_W + 1;
    localparam int unsigned KW    = $clog2(NORM_STEPS + 1);
    localparam int unsigned CMP_W = REM_W + NORM_STEPS + 9;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] NORM = 3'd1;
    localparam logic [2:0] SIN  = 3'd2;
    localparam logic [2:0] COS  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [KW-1:0]     k_q, k_d;
    logic [DATA_W-1:0] sin_q, sin_d;
    logic [DATA_W-1:0] cos_q, cos_d;
    logic [8:0]        angle_q, angle_d;
    logic              op_q, op_d;
    logic [31:0]       lut_angle_q, lut_angle_d;
    logic              in_ready_q, out_valid_q;

    logic [REM_W-1:0]  mag;
    logic [CMP_W-1:0]  step_sub;
    logic [REM_W-1:0]  rem_step;
    logic [REM_W-1:0]  rem_fold;

`ifdef TRIG_SIGNED_EN
    logic neg_q, neg_d;
    logic [REM_W-1:0] ext;

    // Sign-extend by one bit so the magnitude of the most negative input fits.
    assign ext      = {in_angle[ANGLE_W-1], in_angle};
    assign mag      = in_angle[ANGLE_W-1] ? (~ext + REM_W'(1)) : ext;
    assign rem_fold = (neg_q && (rem_step != '0)) ? (REM_W'(360) - rem_step) : rem_step;
`else
    assign mag      = REM_W'(in_angle);
    assign rem_fold = rem_step;
`endif

    // One conditional subtract of 360<<k per NORM cycle.
    assign step_sub = CMP_W'(360) << k_q;
    assign rem_step = (CMP_W'(rem_q) >= step_sub) ? REM_W'(CMP_W'(rem_q) - step_sub) : rem_q;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        k_d         = k_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        angle_d     = angle_q;
        op_d        = op_q;
        lut_angle_d = lut_angle_q;
`ifdef TRIG_SIGNED_EN
        neg_d       = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = mag;
                    k_d     = KW'(NORM_STEPS - 1);
                    state_d = NORM;
`ifdef TRIG_SIGNED_EN
                    neg_d   = in_angle[ANGLE_W-1];
`endif
                end
            end
            NORM: begin
                if (k_q == '0) begin
                    rem_d       = rem_fold;
                    op_d        = 1'b0;
                    lut_angle_d = 32'(rem_fold);
                    state_d     = SIN;
                end else begin
                    rem_d = rem_step;
                    k_d   = k_q - KW'(1);
                end
            end
            SIN: begin
                sin_d   = lut_value;
                op_d    = 1'b1;
                state_d = COS;
            end
            COS: begin
                cos_d   = lut_value;
                angle_d = 9'(rem_q);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            k_q         <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            angle_q     <= '0;
            op_q        <= 1'b0;
            lut_angle_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef TRIG_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            k_q         <= k_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            angle_q     <= angle_d;
            op_q        <= op_d;
            lut_angle_q <= lut_angle_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
`ifdef TRIG_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign sin_out    = sin_q;
    assign cos_out    = cos_q;
    assign angle_out  = angle_q;
    assign lut_op_sel = op_q;
    assign lut_angle  = lut_angle_q;

endmodule

// File: tb/tb_trig_pair_fetch.sv
// Scoreboard bench for trig_pair_fetch, using a behavioural LUT and fixed-latency sampling.
module tb_trig_pair_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_angle;
    logic        lut_op_sel;
    logic [31:0] lut_angle;
    logic [31:0] lut_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sin_out;
    logic [31:0] cos_out;
    logic [8:0]  angle_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {angle, sin, cos} per accepted request.
    logic [72:0] sb_q[$];

    always #5 clk = ~clk;

    trig_pair_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_angle   (in_angle),
        .lut_op_sel (lut_op_sel),
        .lut_angle  (lut_angle),
        .lut_value  (lut_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sin_out    (sin_out),
        .cos_out    (cos_out),
        .angle_out  (angle_out)
    );

    function automatic logic [31:0] lut_model(input logic op, input logic [31:0] a);
        return op ? (32'hC000_0000 + a * 32'd7) : (32'h5000_0000 + a * 32'd3);
    endfunction

    assign lut_value = lut_model(lut_op_sel, lut_angle);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    // Issue one request and check the LUT drive, latency, hold behaviour and result.
    task automatic do_req(input logic [15:0] a, input int exp_ang, input int hold);
        logic [72:0] e;
        wait_ready();
        in_valid = 1'b1;
        in_angle = a;
        @(posedge clk);
        sb_q.push_back({9'(exp_ang), lut_model(1'b0, 32'(exp_ang)), lut_model(1'b1, 32'(exp_ang))});
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", 64'(in_ready), 64'd0);
        repeat (7) tick();
        check("sin_op_sel", 64'(lut_op_sel), 64'd0);
        check("sin_lut_angle", 64'(lut_angle), 64'(exp_ang));
        check("no_early_valid", 64'(out_valid), 64'd0);
        tick();
        check("cos_op_sel", 64'(lut_op_sel), 64'd1);
        check("cos_lut_angle", 64'(lut_angle), 64'(exp_ang));
        tick();
        check("latency_valid", 64'(out_valid), 64'd1);
        e = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_angle = 16'd7;
            tick();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_angle", 64'(angle_out), 64'(e[72:64]));
        end
        in_valid = 1'b0;
        check("angle_out", 64'(angle_out), 64'(e[72:64]));
        check("sin_out", 64'(sin_out), 64'(e[63:32]));
        check("cos_out", 64'(cos_out), 64'(e[31:0]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_dropped", 64'(out_valid), 64'd0);
        check("ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sin", 64'(sin_out), 64'd0);
        check("rst_angle", 64'(angle_out), 64'd0);

        // out_ready held high early has no effect while idle.
        out_ready = 1'b1;
        tick();
        check("idle_out_ready", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        do_req(16'd30, 30, 0);
        do_req(16'd725, 5, 5);
        do_req(16'd360, 0, 0);
        do_req(16'd0, 0, 1);
`ifdef TRIG_SIGNED_EN
        do_req(16'hFFA6, 270, 0);
        do_req(16'h8000, 352, 2);
`endif

        // Reset during the third NORM cycle aborts the request.
        wait_ready();
        in_valid = 1'b1;
        in_angle = 16'd100;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_sin", 64'(sin_out), 64'd0);
        check("abort_cos", 64'(cos_out), 64'd0);
        check("abort_angle", 64'(angle_out), 64'd0);
        check("abort_lut_angle", 64'(lut_angle), 64'd0);
        do_req(16'd45, 45, 0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
